// File: rtl/qe_pkg.sv
// Shared types and constants for the QL expansion-bus W5300 controller.
package qe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } qe_state_e;

  localparam logic [3:0] OFF_CS0     = 4'd0;
  localparam logic [3:0] OFF_RESET   = 4'd4;
  localparam logic [3:0] OFF_STATUS  = 4'd8;
  localparam logic [3:0] QE_REVISION = 4'h1;

  // Wait counter must hold WAIT_CYCLES and never collapse to zero bits.
  function automatic int unsigned wait_cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qe_reset_pulse.sv
// W5300 reset pulse: wizrstl held low RESET_CYCLES clks after rstl release or a trigger.
// A trigger while busy reloads the full count, so the pulse can only be stretched.
module qe_reset_pulse #(
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic clk,
  input  logic rstl,
  input  logic trigger,
  output logic busy,
  output logic wizrstl
);

  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = CW'(RESET_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstl) begin
      cnt_q <= CW'(RESET_CYCLES);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign wizrstl = ~busy;

endmodule

// File: rtl/qe_bus_controller.sv
// QL expansion-bus slave for the W5300 card: window decode, chip selects, DTACK after WAIT_CYCLES+1 clks.
// Status byte at offset 8 exists only when QE_STATUS_REG_EN is defined.
module qe_bus_controller
  import qe_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [1:0]  BASE_HI      = 2'b11,
  parameter logic [3:0]  BASE_PAGE    = 4'b0010,
  parameter int unsigned NUM_CS       = 2,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstl,
  input  logic [ADDR_W-1:0] address,
  input  logic              asl,
  input  logic              dsl,
  input  logic              rdwl,
  output logic              dtackl,
  output logic              dsmcl,
  output logic              dbenl,
  output logic              dbdir,
  output logic [NUM_CS-1:0] csl,
  output logic              wizrdl,
  output logic              wizwrl,
  output logic              wizrstl
`ifdef QE_STATUS_REG_EN
  ,
  output logic [7:0]        stat_data,
  output logic              stat_oel
`endif
);

  localparam int unsigned WW = wait_cnt_w(WAIT_CYCLES);

  qe_state_e         state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [1:0]        asl_sync_q, dsl_sync_q;
  logic              asl_s, dsl_s, hit, hit_q;
  logic              rd_q, rd_d;
  logic [NUM_CS-1:0] csl_q, csl_d;
  logic              dbenl_q, dbenl_d;
  logic              wizrdl_q, wizrdl_d;
  logic              wizwrl_q, wizwrl_d;
  logic              rst_trig, rst_busy, drop;
  logic [3:0]        off;
`ifdef QE_STATUS_REG_EN
  logic              stat_oel_q, stat_oel_d;
  logic              abort_seen_q, abort_seen_d;
`endif

  assign hit   = (address[ADDR_W-1 -: 2] == BASE_HI) && (address[7:4] == BASE_PAGE) && !asl;
  assign dsmcl = hit;
  assign off   = address[3:0];

  always_ff @(posedge clk) begin
    if (!rstl) begin
      asl_sync_q <= 2'b11;
      dsl_sync_q <= 2'b11;
      hit_q      <= 1'b0;
    end else begin
      asl_sync_q <= {asl_sync_q[0], asl};
      dsl_sync_q <= {dsl_sync_q[0], dsl};
      hit_q      <= hit;
    end
  end

  assign asl_s = asl_sync_q[1];
  assign dsl_s = dsl_sync_q[1];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    rd_d     = rd_q;
    csl_d    = csl_q;
    dbenl_d  = dbenl_q;
    wizrdl_d = wizrdl_q;
    wizwrl_d = wizwrl_q;
    rst_trig = 1'b0;
    drop     = 1'b0;
`ifdef QE_STATUS_REG_EN
    stat_oel_d   = stat_oel_q;
    abort_seen_d = abort_seen_q;
`endif
    case (state_q)
      IDLE: begin
        // Strobes are decided once at entry and simply held until the cycle ends.
        if (!asl_s && !dsl_s && hit_q) begin
          state_d = ACCESS;
          rd_d    = rdwl;
          wait_d  = WW'(WAIT_CYCLES);
          if (off < 4'(NUM_CS)) begin
            csl_d    = ~(NUM_CS'(1) << off);
            dbenl_d  = 1'b0;
            wizrdl_d = !rdwl;
            wizwrl_d = rdwl;
          end
          rst_trig = (off == OFF_RESET) && !rdwl;
`ifdef QE_STATUS_REG_EN
          if ((off == OFF_STATUS) && rdwl) begin
            dbenl_d    = 1'b0;
            stat_oel_d = 1'b0;
          end
`endif
        end
      end
      ACCESS: begin
        if (asl_s) begin
          state_d = RELEASE;
          drop    = 1'b1;
`ifdef QE_STATUS_REG_EN
          abort_seen_d = 1'b1;
`endif
        end else if (wait_q == '0) begin
          state_d = ACK;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      ACK: begin
        if (dsl_s) begin
          state_d = RELEASE;
          drop    = 1'b1;
`ifdef QE_STATUS_REG_EN
          // Clear on completion so the read itself still returns the flag.
          if (!stat_oel_q) abort_seen_d = 1'b0;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (drop) begin
      csl_d    = '1;
      dbenl_d  = 1'b1;
      wizrdl_d = 1'b1;
      wizwrl_d = 1'b1;
      rd_d     = 1'b1;
`ifdef QE_STATUS_REG_EN
      stat_oel_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstl) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      rd_q     <= 1'b1;
      csl_q    <= '1;
      dbenl_q  <= 1'b1;
      wizrdl_q <= 1'b1;
      wizwrl_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rd_q     <= rd_d;
      csl_q    <= csl_d;
      dbenl_q  <= dbenl_d;
      wizrdl_q <= wizrdl_d;
      wizwrl_q <= wizwrl_d;
    end
  end

  qe_reset_pulse #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_pulse (
    .clk     (clk),
    .rstl    (rstl),
    .trigger (rst_trig),
    .busy    (rst_busy),
    .wizrstl (wizrstl)
  );

`ifdef QE_STATUS_REG_EN
  always_ff @(posedge clk) begin
    if (!rstl) begin
      stat_oel_q   <= 1'b1;
      abort_seen_q <= 1'b0;
    end else begin
      stat_oel_q   <= stat_oel_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  assign stat_data = {QE_REVISION, 2'b00, abort_seen_q, rst_busy};
  assign stat_oel  = stat_oel_q;
`else
  wire unused_rst_busy = rst_busy;
`endif

  assign dtackl = (state_q == ACK) ? 1'b0 : 1'bz;
  assign dbdir  = rd_q;
  assign csl    = csl_q;
  assign dbenl  = dbenl_q;
  assign wizrdl = wizrdl_q;
  assign wizwrl = wizwrl_q;

endmodule

// File: tb/tb_qe_bus_controller.sv
// Scoreboard bench for qe_bus_controller: three instances (WAIT_CYCLES 2, 0, 4) on a shared bus,
// strobes routed to one selected instance; dtackl is pulled up as on the QL bus.
`timescale 1ns/1ps
module tb_qe_bus_controller;

  localparam int NI = 3;

  function automatic int wc_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 4;
  endfunction

  typedef struct {
    logic [1:0] csl;
    logic       wizrdl;
    logic       wizwrl;
    logic       dbenl;
    logic       dbdir;
    int         lat;
    logic [7:0] stat;
    logic       stat_oel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstl, asl, dsl, rdwl;
  logic [9:0] address;
  int         sel;

  wire [NI-1:0] asl_v, dsl_v, dtackl_o, dsmcl_w, dbenl_w, dbdir_w;
  wire [NI-1:0] wizrdl_w, wizwrl_w, wizrstl_w;
  wire [1:0]    csl_w [NI];
`ifdef QE_STATUS_REG_EN
  wire [7:0]    stat_w [NI];
  wire [NI-1:0] stat_oel_w;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tri1 dtackl_n;
    assign asl_v[g]    = (sel == g) ? asl : 1'b1;
    assign dsl_v[g]    = (sel == g) ? dsl : 1'b1;
    assign dtackl_o[g] = dtackl_n;
    qe_bus_controller #(
      .WAIT_CYCLES(wc_of(g))
    ) u_dut (
      .clk       (clk),
      .rstl      (rstl),
      .address   (address),
      .asl       (asl_v[g]),
      .dsl       (dsl_v[g]),
      .rdwl      (rdwl),
      .dtackl    (dtackl_n),
      .dsmcl     (dsmcl_w[g]),
      .dbenl     (dbenl_w[g]),
      .dbdir     (dbdir_w[g]),
      .csl       (csl_w[g]),
      .wizrdl    (wizrdl_w[g]),
      .wizwrl    (wizwrl_w[g]),
      .wizrstl   (wizrstl_w[g])
`ifdef QE_STATUS_REG_EN
      ,
      .stat_data (stat_w[g]),
      .stat_oel  (stat_oel_w[g])
`endif
    );
  end

  int   checks = 0;
  int   errors = 0;
  exp_t bus_q[$];
  int   pulse_q[$];
  bit   abort_seen_m [NI];
  int   run_len = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int inst, input logic [9:0] a, input logic rd);
    exp_t       e;
    logic [3:0] o;
    o          = a[3:0];
    e.csl      = 2'b11;
    e.wizrdl   = 1'b1;
    e.wizwrl   = 1'b1;
    e.dbenl    = 1'b1;
    e.dbdir    = rd;
    e.lat      = wc_of(inst) + 4;
    e.stat     = 8'h00;
    e.stat_oel = 1'b1;
    if (o == 4'd0 || o == 4'd1) begin
      e.csl    = (o == 4'd0) ? 2'b10 : 2'b01;
      e.dbenl  = 1'b0;
      e.wizrdl = !rd;
      e.wizwrl = rd;
    end
`ifdef QE_STATUS_REG_EN
    if (o == 4'd8 && rd) begin
      e.dbenl    = 1'b0;
      e.stat_oel = 1'b0;
      e.stat     = {4'h1, 2'b00, abort_seen_m[inst], 1'b0};
    end
`endif
    return e;
  endfunction

  task automatic start_cycle(input int inst, input logic [9:0] a, input logic rd);
    sel     = inst;
    address = a;
    rdwl    = rd;
    asl     = 1'b0;
    dsl     = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that lands the FSM back in IDLE.
  task automatic bus_cycle(input int inst, input logic [9:0] a, input logic rd);
    exp_t e;
    int   n;
    bit   acked;
    bus_q.push_back(model(inst, a, rd));
`ifdef QE_STATUS_REG_EN
    if (a[3:0] == 4'd8 && rd) abort_seen_m[inst] = 1'b0;
`endif
    start_cycle(inst, a, rd);
    #1 chk("dsmcl_hit", dsmcl_w[inst], 1'b1);
    n = 0;
    acked = 1'b0;
    while (!acked && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dtackl_o[inst] === 1'b0) acked = 1'b1;
    end
    e = bus_q.pop_front();
    chk("ack_seen", acked, 1'b1);
    chk("dtack_latency", n, e.lat);
    chk("csl", csl_w[inst], e.csl);
    chk("wizrdl", wizrdl_w[inst], e.wizrdl);
    chk("wizwrl", wizwrl_w[inst], e.wizwrl);
    chk("dbenl", dbenl_w[inst], e.dbenl);
    chk("dbdir", dbdir_w[inst], e.dbdir);
`ifdef QE_STATUS_REG_EN
    chk("stat_oel", stat_oel_w[inst], e.stat_oel);
    if (!e.stat_oel) chk("stat_data", stat_w[inst], e.stat);
`endif
    asl = 1'b1;
    dsl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("dtack_released", dtackl_o[inst], 1'b1);
    chk("csl_released", csl_w[inst], 2'b11);
    chk("dbenl_released", dbenl_w[inst], 1'b1);
    chk("strobes_released", {wizrdl_w[inst], wizwrl_w[inst]}, 2'b11);
    @(posedge clk); #1;
  endtask

  // Measures each wizrstl low pulse on instance 0 while rstl is high.
  always @(negedge clk) begin
    if (rstl !== 1'b1) begin
      run_len = 0;
    end else if (wizrstl_w[0] === 1'b0) begin
      run_len++;
    end else if (run_len > 0) begin
      if (pulse_q.size() > 0) chk("rst_pulse_len", run_len, pulse_q.pop_front());
      else                    chk("rst_pulse_unexpected", run_len, 0);
      run_len = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int n;
    bit acked;
    rstl = 1'b0; asl = 1'b1; dsl = 1'b1; rdwl = 1'b1; address = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csl", csl_w[0], 2'b11);
    chk("rst_dbenl", dbenl_w[0], 1'b1);
    chk("rst_strobes", {wizrdl_w[0], wizwrl_w[0]}, 2'b11);
    chk("rst_dbdir", dbdir_w[0], 1'b1);
    chk("rst_dtackl", dtackl_o[0], 1'b1);
    chk("rst_wizrstl", wizrstl_w[0], 1'b0);
    chk("rst_dsmcl", dsmcl_w[0], 1'b0);
    pulse_q.push_back(16);
    rstl = 1'b1;
    @(posedge clk); #1;

    bus_cycle(0, 10'h320, 1'b1);
    bus_cycle(0, 10'h321, 1'b0);
    bus_cycle(1, 10'h321, 1'b0);
    bus_cycle(1, 10'h320, 1'b1);
    bus_cycle(0, 10'h323, 1'b1);
    bus_cycle(0, 10'h328, 1'b1);

    // Outside the card window: no suppress, no cycle.
    start_cycle(0, 10'h120, 1'b1);
    #1 chk("miss_dsmcl", dsmcl_w[0], 1'b0);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dtackl_o[0] !== 1'b1 || csl_w[0] !== 2'b11) lows++;
    end
    chk("miss_no_cycle", lows, 0);
    asl = 1'b1; dsl = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Address strobe dropped one clk into ACCESS on the WAIT_CYCLES=4 instance.
    start_cycle(2, 10'h320, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_access", csl_w[2], 2'b10);
    asl = 1'b1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dtackl_o[2] !== 1'b1) lows++;
    end
    chk("abort_no_dtack", lows, 0);
    chk("abort_csl", csl_w[2], 2'b11);
    abort_seen_m[2] = 1'b1;
    dsl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`ifdef QE_STATUS_REG_EN
    bus_cycle(2, 10'h328, 1'b1);
    bus_cycle(2, 10'h328, 1'b1);
`endif

    repeat (20) @(posedge clk);
    #1;
    pulse_q.push_back(16);
    bus_cycle(0, 10'h324, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    // Back-to-back writes retrigger 10 clks into the first pulse.
    pulse_q.push_back(26);
    bus_cycle(0, 10'h324, 1'b0);
    bus_cycle(0, 10'h324, 1'b0);
    repeat (30) @(posedge clk);
    #1;

    // Reset asserted while the cycle is acknowledged.
    start_cycle(0, 10'h320, 1'b1);
    n = 0;
    acked = 1'b0;
    while (!acked && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dtackl_o[0] === 1'b0) acked = 1'b1;
    end
    chk("rstack_acked", acked, 1'b1);
    rstl = 1'b0;
    @(posedge clk); #1;
    chk("rstack_dtackl", dtackl_o[0], 1'b1);
    chk("rstack_csl", csl_w[0], 2'b11);
    chk("rstack_wizrstl", wizrstl_w[0], 1'b0);
    chk("rstack_strobes", {dbenl_w[0], wizrdl_w[0], wizwrl_w[0]}, 3'b111);
    asl = 1'b1; dsl = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse_q.push_back(16);
    rstl = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    chk("pulse_q_drained", pulse_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
